// File: rtl/frv_alu_issue_if.sv
// Bundle of decode, ALU and writeback signals seen by the execute-stage issue block.
// The master modport is the issue block; the slave modport is its environment.
interface frv_alu_issue_if #(
  parameter int XLEN = 32,
  parameter int PW   = 2,
  parameter int OPW  = 11
);
  logic            flush;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_lhs;
  logic [XLEN-1:0] d_rhs;
  logic [PW:0]     d_pw;
  logic [OPW-1:0]  d_op;
  logic [4:0]      d_rd;
  logic            alu_valid;
  logic            alu_flush;
  logic [PW:0]     alu_pw;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_lhs;
  logic [XLEN-1:0] alu_rhs;
  logic            alu_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_lt;
  logic            alu_eq;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_result;
  logic            wb_lt;
  logic            wb_eq;
  logic [4:0]      wb_rd;

  modport master (
    input  flush, d_valid, d_lhs, d_rhs, d_pw, d_op, d_rd,
    output d_ready,
    output alu_valid, alu_flush, alu_pw, alu_op, alu_lhs, alu_rhs,
    input  alu_ready, alu_result, alu_lt, alu_eq,
    output wb_valid, wb_result, wb_lt, wb_eq, wb_rd,
    input  wb_ready
  );

  modport slave (
    output flush, d_valid, d_lhs, d_rhs, d_pw, d_op, d_rd,
    input  d_ready,
    input  alu_valid, alu_flush, alu_pw, alu_op, alu_lhs, alu_rhs,
    output alu_ready, alu_result, alu_lt, alu_eq,
    input  wb_valid, wb_result, wb_lt, wb_eq, wb_rd,
    output wb_ready
  );
endinterface

// File: rtl/frv_alu_issue.sv
// Execute-stage ALU issue block: stage p0 presents a decoded op to the combinational
// ALU, stage p1 holds its result for writeback. One op per cycle, flushable.
module frv_alu_issue #(
  parameter int XLEN = 32,
  parameter int PW   = 2,
  parameter int OPW  = 11
) (
  input  logic                g_clk,
  input  logic                g_reset,
  frv_alu_issue_if.master     bus
);

  logic            vld_p0_q, vld_p0_d;
  logic [PW:0]     pw_p0_q,  pw_p0_d;
  logic [OPW-1:0]  op_p0_q,  op_p0_d;
  logic [XLEN-1:0] lhs_p0_q, lhs_p0_d;
  logic [XLEN-1:0] rhs_p0_q, rhs_p0_d;
  logic [4:0]      rd_p0_q,  rd_p0_d;

  logic            vld_p1_q,    vld_p1_d;
  logic [XLEN-1:0] result_p1_q, result_p1_d;
  logic            lt_p1_q,     lt_p1_d;
  logic            eq_p1_q,     eq_p1_d;
  logic [4:0]      rd_p1_q,     rd_p1_d;

  logic b_free, a_fire, d_ready, d_fire;

  always_comb begin
    b_free  = !vld_p1_q || bus.wb_ready;
    a_fire  = vld_p0_q && bus.alu_ready && b_free;
    d_ready = (!vld_p0_q || a_fire) && !bus.flush;
    d_fire  = bus.d_valid && d_ready;

    vld_p0_d    = vld_p0_q;
    pw_p0_d     = pw_p0_q;
    op_p0_d     = op_p0_q;
    lhs_p0_d    = lhs_p0_q;
    rhs_p0_d    = rhs_p0_q;
    rd_p0_d     = rd_p0_q;
    vld_p1_d    = vld_p1_q;
    result_p1_d = result_p1_q;
    lt_p1_d     = lt_p1_q;
    eq_p1_d     = eq_p1_q;
    rd_p1_d     = rd_p1_q;

    // p0: a new op may replace the one leaving for the ALU in the same cycle
    if (d_fire) begin
      vld_p0_d = 1'b1;
      pw_p0_d  = bus.d_pw;
      op_p0_d  = bus.d_op;
      lhs_p0_d = bus.d_lhs;
      rhs_p0_d = bus.d_rhs;
      rd_p0_d  = bus.d_rd;
    end else if (a_fire) begin
      vld_p0_d = 1'b0;
    end

    // p1: a completing op overwrites a result being consumed this cycle
    if (a_fire) begin
      vld_p1_d    = 1'b1;
      result_p1_d = bus.alu_result;
      lt_p1_d     = bus.alu_lt;
      eq_p1_d     = bus.alu_eq;
      rd_p1_d     = rd_p0_q;
    end else if (bus.wb_ready) begin
      vld_p1_d = 1'b0;
    end

    // Flush drops both stages, including an op completing in the same cycle
    if (bus.flush) begin
      vld_p0_d = 1'b0;
      vld_p1_d = 1'b0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      vld_p0_q    <= 1'b0;
      pw_p0_q     <= '0;
      op_p0_q     <= '0;
      lhs_p0_q    <= '0;
      rhs_p0_q    <= '0;
      rd_p0_q     <= '0;
      vld_p1_q    <= 1'b0;
      result_p1_q <= '0;
      lt_p1_q     <= 1'b0;
      eq_p1_q     <= 1'b0;
      rd_p1_q     <= '0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      pw_p0_q     <= pw_p0_d;
      op_p0_q     <= op_p0_d;
      lhs_p0_q    <= lhs_p0_d;
      rhs_p0_q    <= rhs_p0_d;
      rd_p0_q     <= rd_p0_d;
      vld_p1_q    <= vld_p1_d;
      result_p1_q <= result_p1_d;
      lt_p1_q     <= lt_p1_d;
      eq_p1_q     <= eq_p1_d;
      rd_p1_q     <= rd_p1_d;
    end
  end

  assign bus.d_ready   = d_ready;
  assign bus.alu_valid = vld_p0_q;
  assign bus.alu_flush = bus.flush;
  assign bus.alu_pw    = pw_p0_q;
  assign bus.alu_op    = op_p0_q;
  assign bus.alu_lhs   = lhs_p0_q;
  assign bus.alu_rhs   = rhs_p0_q;
  assign bus.wb_valid  = vld_p1_q;
  assign bus.wb_result = result_p1_q;
  assign bus.wb_lt     = lt_p1_q;
  assign bus.wb_eq     = eq_p1_q;
  assign bus.wb_rd     = rd_p1_q;

endmodule

// File: tb/tb_frv_alu_issue.sv
// Directed bench for frv_alu_issue with a small behavioural ALU on the far side.
module tb_frv_alu_issue;

  localparam logic [10:0] OP_ADD = 11'b100_0000_0000;
  localparam logic [10:0] OP_SUB = 11'b010_0000_0000;
  localparam logic [10:0] OP_XOR = 11'b001_0000_0000;
  localparam logic [10:0] OP_OR  = 11'b000_1000_0000;
  localparam logic [10:0] OP_AND = 11'b000_0100_0000;
  localparam logic [10:0] OP_CMP = 11'b000_0000_0010;
  localparam logic [10:0] OP_UNS = 11'b000_0000_0001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  frv_alu_issue_if #(.XLEN(32), .PW(2), .OPW(11)) bus ();

  frv_alu_issue #(.XLEN(32), .PW(2), .OPW(11)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU answering whatever stage p0 presents
  always_comb begin
    bus.alu_lt = bus.alu_op[0] ? (bus.alu_lhs < bus.alu_rhs)
                               : ($signed(bus.alu_lhs) < $signed(bus.alu_rhs));
    bus.alu_eq = (bus.alu_lhs == bus.alu_rhs);
    bus.alu_result = 32'h0;
    if (bus.alu_op[10])      bus.alu_result = bus.alu_lhs + bus.alu_rhs;
    else if (bus.alu_op[9])  bus.alu_result = bus.alu_lhs - bus.alu_rhs;
    else if (bus.alu_op[8])  bus.alu_result = bus.alu_lhs ^ bus.alu_rhs;
    else if (bus.alu_op[7])  bus.alu_result = bus.alu_lhs | bus.alu_rhs;
    else if (bus.alu_op[6])  bus.alu_result = bus.alu_lhs & bus.alu_rhs;
    else if (bus.alu_op[1])  bus.alu_result = {31'h0, bus.alu_lt};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                       input logic [4:0] rd, input logic [2:0] pw);
    bus.d_valid = 1'b1;
    bus.d_op    = op;
    bus.d_lhs   = lhs;
    bus.d_rhs   = rhs;
    bus.d_rd    = rd;
    bus.d_pw    = pw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got %b want 0", bus.alu_valid); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    checks++; if (bus.alu_lhs !== 32'h0) begin errors++; $display("FAIL reset_alu_lhs got %h want 0", bus.alu_lhs); end
    checks++; if (bus.wb_result !== 32'h0 || bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb got %h/%0d want 0/0", bus.wb_result, bus.wb_rd); end
    rst = 1'b0;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready got %b want 1", bus.d_ready); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.alu_flush !== 1'b1 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL flush_comb got alu_flush=%b d_ready=%b want 1/0", bus.alu_flush, bus.d_ready); end
    bus.flush = 1'b0;
    #1;
  endtask

  task automatic test_single();
    bus.wb_ready  = 1'b1;
    bus.alu_ready = 1'b1;
    drive(OP_ADD, 32'h5, 32'h3, 5'd7, 3'd0);
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL single_d_ready got %b want 1", bus.d_ready); end
    tick();
    bus.d_valid = 1'b0;
    checks++; if (bus.alu_valid !== 1'b1 || bus.alu_lhs !== 32'h5 || bus.alu_rhs !== 32'h3) begin errors++; $display("FAIL single_issue got v=%b lhs=%h rhs=%h want 1/5/3", bus.alu_valid, bus.alu_lhs, bus.alu_rhs); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_early got %b want 0", bus.wb_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'h8 || bus.wb_rd !== 5'd7) begin errors++; $display("FAIL single_wb got v=%b res=%h rd=%0d want 1/8/7", bus.wb_valid, bus.wb_result, bus.wb_rd); end
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL single_alu_drain got %b want 0", bus.alu_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_drain got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [4];
    logic [31:0] lhs [4];
    logic [31:0] rhs [4];
    logic [31:0] exp_res [4];
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_CMP | OP_UNS};
    lhs = '{32'h1, 32'h9, 32'hF0, 32'h1};
    rhs = '{32'h1, 32'h4, 32'hFF, 32'h2};
    exp_res = '{32'h2, 32'h5, 32'h0F, 32'h1};
    bus.wb_ready  = 1'b1;
    bus.alu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive(ops[i], lhs[i], rhs[i], 5'(i + 1), 3'd0);
        #1;
        checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL b2b_d_ready[%0d] got %b want 1", i, bus.d_ready); end
      end else begin
        bus.d_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== exp_res[i-1] || bus.wb_rd !== 5'(i)) begin errors++; $display("FAIL b2b_wb[%0d] got v=%b res=%h rd=%0d want 1/%h/%0d", i - 1, bus.wb_valid, bus.wb_result, bus.wb_rd, exp_res[i-1], i); end
      end
      if (i == 4) begin
        checks++; if (bus.wb_lt !== 1'b1) begin errors++; $display("FAIL b2b_cmp_lt got %b want 1", bus.wb_lt); end
      end
    end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_backpressure();
    bus.wb_ready  = 1'b0;
    bus.alu_ready = 1'b1;
    drive(OP_ADD, 32'd10, 32'd20, 5'd10, 3'd0);
    tick();
    drive(OP_ADD, 32'd100, 32'd1, 5'd11, 3'd0);
    tick();
    drive(OP_OR, 32'h55, 32'hAA, 5'd12, 3'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL bp_d_ready[%0d] got %b want 0", k, bus.d_ready); end
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'd30 || bus.wb_rd !== 5'd10) begin errors++; $display("FAIL bp_wb_hold[%0d] got v=%b res=%h rd=%0d want 1/1e/10", k, bus.wb_valid, bus.wb_result, bus.wb_rd); end
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_lhs !== 32'd100) begin errors++; $display("FAIL bp_a_hold[%0d] got v=%b lhs=%h want 1/64", k, bus.alu_valid, bus.alu_lhs); end
      tick();
    end
    bus.d_valid  = 1'b0;
    bus.wb_ready = 1'b1;
    tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'd101 || bus.wb_rd !== 5'd11) begin errors++; $display("FAIL bp_second got v=%b res=%h rd=%0d want 1/65/11", bus.wb_valid, bus.wb_result, bus.wb_rd); end
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL bp_a_drain got %b want 0", bus.alu_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_flush();
    bus.wb_ready  = 1'b1;
    bus.alu_ready = 1'b1;
    drive(OP_ADD, 32'd1, 32'd2, 5'd20, 3'd0);
    tick();
    drive(OP_ADD, 32'd3, 32'd4, 5'd21, 3'd0);
    tick();
    drive(OP_ADD, 32'd5, 32'd6, 5'd22, 3'd0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b0 || bus.alu_flush !== 1'b1) begin errors++; $display("FAIL flush_ready got d_ready=%b alu_flush=%b want 0/1", bus.d_ready, bus.alu_flush); end
    checks++; if (bus.alu_valid !== 1'b1 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL flush_setup got a=%b b=%b want 1/1", bus.alu_valid, bus.wb_valid); end
    tick();
    bus.flush   = 1'b0;
    bus.d_valid = 1'b0;
    checks++; if (bus.alu_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got a=%b b=%b want 0/0", bus.alu_valid, bus.wb_valid); end
    tick();
    checks++; if (bus.alu_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got a=%b b=%b want 0/0", bus.alu_valid, bus.wb_valid); end
  endtask

  task automatic test_reset_mid();
    bus.wb_ready  = 1'b0;
    bus.alu_ready = 1'b1;
    drive(OP_XOR, 32'hFFFF_0000, 32'h1234_5678, 5'd25, 3'd5);
    tick();
    drive(OP_ADD, 32'hAAAA_AAAA, 32'h1, 5'd26, 3'd6);
    tick();
    bus.d_valid = 1'b0;
    checks++; if (bus.alu_valid !== 1'b1 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup got a=%b b=%b want 1/1", bus.alu_valid, bus.wb_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.alu_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got a=%b b=%b want 0/0", bus.alu_valid, bus.wb_valid); end
    checks++; if (bus.alu_lhs !== 32'h0 || bus.alu_rhs !== 32'h0 || bus.alu_op !== 11'h0 || bus.alu_pw !== 3'd0) begin errors++; $display("FAIL rmid_a_regs got lhs=%h rhs=%h op=%h pw=%0d want 0", bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_pw); end
    checks++; if (bus.wb_result !== 32'h0 || bus.wb_rd !== 5'd0 || bus.wb_lt !== 1'b0 || bus.wb_eq !== 1'b0) begin errors++; $display("FAIL rmid_b_regs got res=%h rd=%0d lt=%b eq=%b want 0", bus.wb_result, bus.wb_rd, bus.wb_lt, bus.wb_eq); end
    bus.wb_ready = 1'b1;
    drive(OP_ADD, 32'd2, 32'd2, 5'd5, 3'd0);
    tick();
    bus.d_valid = 1'b0;
    checks++; if (bus.alu_valid !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_new_issue got a=%b b=%b want 1/0", bus.alu_valid, bus.wb_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'd4 || bus.wb_rd !== 5'd5) begin errors++; $display("FAIL rmid_new_wb got v=%b res=%h rd=%0d want 1/4/5", bus.wb_valid, bus.wb_result, bus.wb_rd); end
    tick();
  endtask

  task automatic test_alu_stall();
    bus.wb_ready  = 1'b1;
    bus.alu_ready = 1'b0;
    drive(OP_AND, 32'hFF, 32'h0F, 5'd9, 3'd3);
    tick();
    drive(OP_ADD, 32'hDEAD, 32'h1, 5'd30, 3'd1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL stall_d_ready[%0d] got %b want 0", k, bus.d_ready); end
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_lhs !== 32'hFF || bus.alu_rhs !== 32'h0F || bus.alu_pw !== 3'd3 || bus.alu_op !== OP_AND) begin errors++; $display("FAIL stall_hold[%0d] got v=%b lhs=%h rhs=%h pw=%0d op=%h want 1/ff/0f/3/%h", k, bus.alu_valid, bus.alu_lhs, bus.alu_rhs, bus.alu_pw, bus.alu_op, OP_AND); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stall_wb[%0d] got %b want 0", k, bus.wb_valid); end
      tick();
    end
    bus.d_valid   = 1'b0;
    bus.alu_ready = 1'b1;
    tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'h0F || bus.wb_rd !== 5'd9) begin errors++; $display("FAIL stall_release got v=%b res=%h rd=%0d want 1/0f/9", bus.wb_valid, bus.wb_result, bus.wb_rd); end
    tick();
  endtask

  task automatic test_zero_op();
    bus.wb_ready  = 1'b1;
    bus.alu_ready = 1'b1;
    drive(11'h0, 32'h1234, 32'h1234, 5'd17, 3'd2);
    tick();
    bus.d_valid = 1'b0;
    checks++; if (bus.alu_valid !== 1'b1 || bus.alu_op !== 11'h0 || bus.alu_pw !== 3'd2) begin errors++; $display("FAIL zero_issue got v=%b op=%h pw=%0d want 1/0/2", bus.alu_valid, bus.alu_op, bus.alu_pw); end
    tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'h0 || bus.wb_eq !== 1'b1 || bus.wb_rd !== 5'd17) begin errors++; $display("FAIL zero_wb got v=%b res=%h eq=%b rd=%0d want 1/0/1/17", bus.wb_valid, bus.wb_result, bus.wb_eq, bus.wb_rd); end
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_lhs     = '0;
    bus.d_rhs     = '0;
    bus.d_pw      = '0;
    bus.d_op      = '0;
    bus.d_rd      = '0;
    bus.alu_ready = 1'b1;
    bus.wb_ready  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_alu_stall();
    test_zero_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frv_alu_issue.md
Name: frv_alu_issue

Overview:
- Issue-side initiator for the execute-stage ALU; the counterpart that drives the ALU's valid/op/operand interface and collects its results.
- Registers decoded ALU operations from decode and presents them to the combinational ALU.
- Captures result, lt and eq into a writeback register with valid/ready back-pressure.
- Two-entry pipeline with a flush input; sustains one op per cycle.

Parameters:
XLEN, 32, datapath width; XL = XLEN-1.
PW, 2, pack-width field MSB; the pack-width field is PW+1 bits.
OPW, 11, op bundle width. Bit order [10:0] = add, sub, xor, or, and, shf, rot, shf_left, shf_arith, cmp, unsigned.

Ports:
g_clk  in  1  global clock; all state updates on rising edge
g_reset  in  1  synchronous reset, active-high
flush  in  1  discard all in-flight ops
d_valid  in  1  decode presents an ALU op
d_ready  out  1  issue register can accept
d_lhs  in  XLEN  left operand
d_rhs  in  XLEN  right operand
d_pw  in  PW+1  pack width
d_op  in  OPW  op bundle
d_rd  in  5  destination register tag
alu_valid  out  1  issue register holds a valid op
alu_flush  out  1  equals flush
alu_pw  out  PW+1  registered pack width
alu_op  out  OPW  registered op bundle; top level breaks it out to the ALU's alu_op_* bits
alu_lhs  out  XLEN  registered left operand
alu_rhs  out  XLEN  registered right operand
alu_ready  in  1  ALU can complete this cycle
alu_result  in  XLEN  ALU result
alu_lt  in  1  ALU less-than flag
alu_eq  in  1  ALU equal flag
wb_valid  out  1  result register valid
wb_ready  in  1  writeback consumes result
wb_result  out  XLEN  captured result
wb_lt  out  1  captured lt
wb_eq  out  1  captured eq
wb_rd  out  5  captured destination tag

Behaviour:
- Stage A (issue) registers: a_valid, pw, op, lhs, rhs, rd.
  - alu_valid = a_valid.
  - alu_* outputs are driven directly from the Stage A registers.
- Stage B (writeback) registers: b_valid, result, lt, eq, rd.
  - wb_valid = b_valid.
- Handshake events:
  - b_free = !b_valid || wb_ready.
  - a_fire = a_valid && alu_ready && b_free.
  - d_ready = (!a_valid || a_fire) && !flush. Combinational; depends on wb_ready and alu_ready.
  - d_fire = d_valid && d_ready.
- Stage A update:
  - On d_fire, load all fields and set a_valid.
  - Else on a_fire, clear a_valid.
  - Else hold. Operands must be stable while a_valid && !a_fire.
- Stage B update:
  - On a_fire, capture alu_result/alu_lt/alu_eq and the Stage A rd; set b_valid.
  - Else if wb_ready, clear b_valid.
  - Else hold.
- Simultaneous d_fire and a_fire: Stage A reloads with the new op while Stage B takes the old one. Gives back-to-back throughput of 1 op/cycle.
- Simultaneous wb_ready and a_fire: Stage B is overwritten with the new result; b_valid stays 1.
- Latency: op accepted at edge N → alu_valid high in cycle N+1 → wb_valid high in cycle N+2 (no stalls).
- Back-pressure: wb_ready low with b_valid high holds Stage B. Stage A then holds (a_fire=0), and d_ready falls while a_valid.
- Flush:
  - Clears a_valid and b_valid at the next edge.
  - d_ready is 0 during flush, so nothing is accepted that cycle.
  - A completing a_fire in the flush cycle is discarded.
  - Data registers need not clear.
- Reset (g_reset=1 at edge): every output register goes to 0, i.e. a_valid, b_valid, alu_pw, alu_op, alu_lhs, alu_rhs, wb_result, wb_lt, wb_eq, wb_rd all 0. Reset overrides flush and all handshakes. Reset mid-operation drops both in-flight ops.
- After reset deasserts: d_ready=1 when flush=0 (combinational); alu_flush follows flush.
- Zero op bundle: passed through unchanged; the result is whatever the ALU returns (0). No error flagged.
- No arithmetic is performed locally; widths pass through unchanged.

Test Plan:
1. Reset, then d_op=add, lhs=0x00000005, rhs=0x00000003, rd=7, wb_ready=1 → alu_valid at N+1 with alu_lhs=5; wb_valid at N+2 with wb_result=0x8, wb_rd=7.
2. Stream 4 ops (add 1+1, sub 9-4, xor 0xF0^0xFF, cmp-unsigned 1<2) with wb_ready=1 → d_ready held 1; wb_result = 2, 5, 0x0F, 1 on consecutive cycles; last op has wb_lt=1.
3. Hold wb_ready=0 for 3 cycles with two ops sent → wb holds the first result, Stage A holds the second, d_ready=0. Release → results emerge in order; no loss or duplication.
4. Assert flush in the cycle Stage A fires with b_valid=1 → next cycle alu_valid=0 and wb_valid=0; the d_valid offered that cycle is not accepted.
5. Assert g_reset while both stages are valid → next cycle all outputs 0; a new op afterwards completes with 2-cycle latency.
6. Drive alu_ready=0 for 2 cycles → alu_* outputs stable and d_ready=0. On alu_ready=1 → captured with the correct rd.
